// File: rtl/spell_wb_pkg.sv
// rtl/spell_wb_pkg.sv - shared types and constants for the SRAM Wishbone bridge
//
// Purpose: state encoding, bus widths and the default error read word used by
// spell_sram_wb_bridge.
// Ports: none (package).
package spell_wb_pkg;

  localparam int WB_ADDR_W = 8;
  localparam int WB_DATA_W = 32;
  localparam int WB_SEL_W  = 4;

  // Read word handed upstream when the slave never acknowledges.
  localparam logic [WB_DATA_W-1:0] WB_ERROR_DATA = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    DONE    = 2'd2,
    RELEASE = 2'd3
  } wb_state_e;

endpackage

// File: rtl/spell_sram_wb_bridge.sv
// rtl/spell_sram_wb_bridge.sv - registered single-beat Wishbone master with bus timeout
//
// Purpose: latches one combinational SRAM request from the memory stage, runs a
// clean classic Wishbone cycle to the OpenRAM slave, captures the read word and
// returns a one-cycle ack upstream. A saturating counter aborts the cycle when
// the slave stays silent for TIMEOUT_CYCLES cycles.
// Ports:
//   clock, reset                 clock; synchronous active-low reset
//   req_cyc_i/stb_i/we_i/sel_i/addr_i/dat_i   upstream request
//   req_dat_o, req_ack_o         upstream read word and completion pulse
//   wb_cyc_o/stb_o/we_o/sel_o/adr_o/dat_o     Wishbone master outputs
//   wb_dat_i, wb_ack_i           Wishbone slave response
//   busy_o                       high whenever the FSM is not idle
//   timeout_o                    sticky timeout flag, cleared by reset only
module spell_sram_wb_bridge
  import spell_wb_pkg::*;
#(
  parameter int unsigned           TIMEOUT_CYCLES = 255,
  parameter logic [WB_DATA_W-1:0] ERROR_DATA     = WB_ERROR_DATA
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 req_cyc_i,
  input  logic                 req_stb_i,
  input  logic                 req_we_i,
  input  logic [WB_SEL_W-1:0]  req_sel_i,
  input  logic [WB_ADDR_W-1:0] req_addr_i,
  input  logic [WB_DATA_W-1:0] req_dat_i,
  output logic [WB_DATA_W-1:0] req_dat_o,
  output logic                 req_ack_o,
  output logic                 wb_cyc_o,
  output logic                 wb_stb_o,
  output logic                 wb_we_o,
  output logic [WB_SEL_W-1:0]  wb_sel_o,
  output logic [WB_ADDR_W-1:0] wb_adr_o,
  output logic [WB_DATA_W-1:0] wb_dat_o,
  input  logic [WB_DATA_W-1:0] wb_dat_i,
  input  logic                 wb_ack_i,
  output logic                 busy_o,
  output logic                 timeout_o
);

  localparam logic [7:0] TMO_LIMIT = 8'(TIMEOUT_CYCLES);

  wb_state_e  state;
  logic [7:0] tmo_cnt;
  logic       withdrawn;   // upstream strobe seen low during the current REQ
  logic       req_valid;
  logic       tmo_hit;
  logic       still_wanted;

  always_comb begin
    req_valid    = req_cyc_i && req_stb_i;
    // This REQ edge is the TIMEOUT_CYCLES-th one; compare in 9 bits so the
    // increment can never wrap.
    tmo_hit      = ({1'b0, tmo_cnt} + 9'd1) >= {1'b0, TMO_LIMIT};
    // A strobe drop on the completing edge also counts as a withdrawal.
    still_wanted = req_stb_i && !withdrawn;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state     <= IDLE;
      tmo_cnt   <= 8'd0;
      withdrawn <= 1'b0;
      req_dat_o <= '0;
      req_ack_o <= 1'b0;
      wb_cyc_o  <= 1'b0;
      wb_stb_o  <= 1'b0;
      wb_we_o   <= 1'b0;
      wb_sel_o  <= '0;
      wb_adr_o  <= '0;
      wb_dat_o  <= '0;
      busy_o    <= 1'b0;
      timeout_o <= 1'b0;
    end else begin
      req_ack_o <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            wb_we_o   <= req_we_i;
            wb_sel_o  <= req_sel_i;
            wb_adr_o  <= req_addr_i;
            wb_dat_o  <= req_dat_i;
            wb_cyc_o  <= 1'b1;
            wb_stb_o  <= 1'b1;
            tmo_cnt   <= 8'd0;
            withdrawn <= 1'b0;
            busy_o    <= 1'b1;
            state     <= REQ;
          end
        end

        REQ: begin
          if (!req_stb_i) begin
            withdrawn <= 1'b1;
          end
          // The bus cycle always runs to ack or timeout; an ack on the
          // limit edge takes priority over the timeout.
          if (wb_ack_i || tmo_hit) begin
            wb_cyc_o <= 1'b0;
            wb_stb_o <= 1'b0;
            if (wb_ack_i) begin
              if (!wb_we_o) begin
                req_dat_o <= wb_dat_i;
              end
            end else begin
              timeout_o <= 1'b1;
              tmo_cnt   <= TMO_LIMIT;
              if (!wb_we_o) begin
                req_dat_o <= ERROR_DATA;
              end
            end
            if (still_wanted) begin
              req_ack_o <= 1'b1;
              state     <= DONE;
            end else begin
              busy_o <= 1'b0;
              state  <= IDLE;
            end
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
        end

        DONE: begin
          if (req_stb_i) begin
            state <= RELEASE;
          end else begin
            busy_o <= 1'b0;
            state  <= IDLE;
          end
        end

        RELEASE: begin
          // Hold off until the served request is withdrawn so it is not
          // issued a second time.
          if (!req_stb_i) begin
            busy_o <= 1'b0;
            state  <= IDLE;
          end
        end

        default: begin
          busy_o <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/spell_sram_wb_bridge.md
Name: spell_sram_wb_bridge

Overview:
- Registered Wishbone master between the memory stage's combinational SRAM request outputs (cyc/stb/we/sel/addr/dat) and the OpenRAM Wishbone slave.
- Latches one request, drives a clean single-beat classic Wishbone cycle and captures the read word.
- Returns a one-cycle ack upstream.
- Adds a bus timeout so a missing slave ack cannot hang the CPU.

Parameters:
- TIMEOUT_CYCLES, 255: cycles in REQ without wb_ack_i before abort; legal range 1..255.
- ERROR_DATA, 32'hFFFF_FFFF: read word returned upstream on timeout.

Ports:
- clock  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-low reset
- req_cyc_i  in  1  upstream cycle request
- req_stb_i  in  1  upstream strobe; a request is valid only when req_cyc_i && req_stb_i
- req_we_i  in  1  1 = write
- req_sel_i  in  4  byte lane select
- req_addr_i  in  8  word address
- req_dat_i  in  32  write data
- req_dat_o  out  32  read word, held until next completed read or reset
- req_ack_o  out  1  one-cycle completion pulse
- wb_cyc_o  out  1  Wishbone cycle
- wb_stb_o  out  1  Wishbone strobe
- wb_we_o  out  1  Wishbone write enable
- wb_sel_o  out  4  Wishbone byte select
- wb_adr_o  out  8  Wishbone address
- wb_dat_o  out  32  Wishbone write data
- wb_dat_i  in  32  Wishbone read data
- wb_ack_i  in  1  Wishbone ack
- busy_o  out  1  high in any state other than IDLE
- timeout_o  out  1  sticky; set on any timeout, cleared only by reset

Behaviour:
- Reset (reset==0 at a clock edge):
  - State goes to IDLE; timeout counter cleared.
  - All outputs registered and 0 on the following cycle: wb_*_o, req_ack_o, req_dat_o, busy_o, timeout_o.
  - Reset in any state aborts immediately; wb_cyc_o/wb_stb_o fall on that edge.
- States: IDLE, REQ, DONE, RELEASE.
- IDLE:
  - On req_cyc_i && req_stb_i, latch we/sel/addr/dat into the wb_*_o registers, assert wb_cyc_o = wb_stb_o = 1, clear the counter, go to REQ.
  - Otherwise wb_cyc_o = wb_stb_o = 0.
- REQ:
  - wb_*_o stable; upstream input changes are ignored.
  - Counter increments each cycle.
  - On wb_ack_i: if read, req_dat_o <= wb_dat_i; drop cyc/stb; go to DONE.
  - If the counter reaches TIMEOUT_CYCLES without ack: drop cyc/stb, set timeout_o, load req_dat_o <= ERROR_DATA if read, go to DONE.
  - An ack arriving on the same cycle the count hits the limit wins: normal completion, no timeout.
- DONE:
  - req_ack_o = 1 for exactly this one cycle.
  - Go to RELEASE if req_stb_i is still high, else to IDLE.
- RELEASE:
  - Wait until req_stb_i == 0, then go to IDLE.
  - Prevents re-issuing a still-asserted, already-served request.
- Upstream withdrawal:
  - If req_stb_i falls during REQ, the bus cycle still completes (ack or timeout).
  - req_ack_o is suppressed and the FSM goes directly to IDLE. Wishbone rule: cyc/stb are never dropped without ack or timeout.
- Latency:
  - Request visible at edge N.
  - wb_cyc_o high from N+1.
  - Slave ack sampled at edge M.
  - req_ack_o high during cycle M+1.
  - Minimum 2 cycles request-to-ack with a zero-wait slave.
- Writes: req_dat_o is unchanged.
- Timeout counter: 8 bits, never wraps; it saturates at the limit.

Decomposition:
- Package spell_wb_pkg holds:
  - the state enum (IDLE, REQ, DONE, RELEASE, 2-bit encoding);
  - width localparams WB_ADDR_W = 8, WB_DATA_W = 32, WB_SEL_W = 4;
  - the default ERROR_DATA constant.
- No sub-module; the FSM and timeout counter live in one module.

Test Plan:
1. Read, zero-wait slave: req addr 8'h05, sel 4'b0010, wb_ack_i one cycle after wb_cyc_o with wb_dat_i = 32'hDEADBEEF -> req_dat_o = 32'hDEADBEEF, one req_ack_o pulse two cycles after the request, wb_adr_o = 8'h05.
2. Write with 3 wait states: addr 8'h41, sel 4'b1000, dat 32'hA5A5A5A5 -> wb_we_o = 1 and wb_dat_o/sel/adr stable for 4 cycles, req_ack_o one cycle after ack, req_dat_o unchanged.
3. Timeout, TIMEOUT_CYCLES = 4, slave never acks, read -> cyc/stb drop after 4 REQ cycles, timeout_o = 1 and stays 1, req_dat_o = 32'hFFFFFFFF, single req_ack_o.
4. Request held high for 10 cycles after ack -> exactly one Wishbone cycle, FSM in RELEASE until stb drops; a new request then issues a second cycle.
5. Reset asserted mid-REQ -> next cycle all outputs 0, busy_o = 0; a later ack on wb_ack_i produces no req_ack_o.
6. req_stb_i dropped in REQ, slave acks 2 cycles later -> bus cycle completes, no req_ack_o, FSM back in IDLE.
